// File: rtl/adv7511_init_sequencer_if.sv
// Transaction handshake between the ADV7511 init sequencer (master) and the I2C byte master (slave).
// The offer side is valid/ready; completion comes back as a done pulse qualified by nack.
interface adv7511_init_sequencer_if #(
  parameter int NBYTES = 3
);
  logic                tx_valid_o;
  logic                tx_ready_i;
  logic [NBYTES*8-1:0] tx_data_o;
  logic                tx_done_i;
  logic                tx_nack_i;

  modport master (
    output tx_valid_o,
    output tx_data_o,
    input  tx_ready_i,
    input  tx_done_i,
    input  tx_nack_i
  );

  modport slave (
    input  tx_valid_o,
    input  tx_data_o,
    output tx_ready_i,
    output tx_done_i,
    output tx_nack_i
  );
endinterface

// File: rtl/adv7511_init_sequencer.sv
// Power-up / hot-plug register-init sequencer for the ADV7511: walks a fixed write table through the I2C master.
// Optional feature macro ADV_INIT_RETRY_EN: failed writes are retried up to MAX_RETRY times before ERROR.
module adv7511_init_sequencer #(
  parameter int         NBYTES         = 3,
  parameter int         NTRANS         = 10,
  parameter logic [7:0] DEV_ADDR       = 8'h72,
  parameter int         POWERUP_CYCLES = 200,
  parameter int         GAP_CYCLES     = 16,
  parameter int         TIMEOUT_CYCLES = 4096,
  parameter int         MAX_RETRY      = 3
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            start_i,
  input  logic                            hpd_i,
  adv7511_init_sequencer_if.master        tx,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic [3:0]                      trans_idx_o
);

  localparam int TX_W    = NBYTES * 8;
  localparam int CNT_M0  = (POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX = (CNT_M0 > TIMEOUT_CYCLES) ? CNT_M0 : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       IDX_LAST = 4'(NTRANS - 1);

  if (NTRANS < 1 || NTRANS > 10) begin : g_bad_ntrans
    $error("adv7511_init_sequencer: NTRANS must be within 1..10");
  end
  if (NBYTES < 3) begin : g_bad_nbytes
    $error("adv7511_init_sequencer: NBYTES must be at least 3");
  end
  if (MAX_RETRY < 0 || MAX_RETRY > 15) begin : g_bad_retry
    $error("adv7511_init_sequencer: MAX_RETRY must be within 0..15");
  end
  if (POWERUP_CYCLES < 1 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("adv7511_init_sequencer: cycle counts must be at least 1");
  end

  typedef enum logic [2:0] {
    S_WAIT_PWR,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  // {reg_addr, reg_data} for each init step
  function automatic logic [15:0] tbl_entry(input logic [3:0] idx);
    case (idx)
      4'd0:    tbl_entry = 16'h4110;
      4'd1:    tbl_entry = 16'h9803;
      4'd2:    tbl_entry = 16'h9AE0;
      4'd3:    tbl_entry = 16'h9C30;
      4'd4:    tbl_entry = 16'h9D61;
      4'd5:    tbl_entry = 16'hA2A4;
      4'd6:    tbl_entry = 16'hA3A4;
      4'd7:    tbl_entry = 16'hE0D0;
      4'd8:    tbl_entry = 16'hF900;
      4'd9:    tbl_entry = 16'h1500;
      default: tbl_entry = 16'h0000;
    endcase
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic               pend_q, pend_d;
  logic               tx_valid_q, tx_valid_d;
  logic [TX_W-1:0]    tx_data_q, tx_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef ADV_INIT_RETRY_EN
  logic [3:0]         retry_q, retry_d;
`endif

  logic hpd_s1_q, hpd_s2_q, hpd_s3_q;
  logic hpd_rise, restart_ev, restart_now, do_restart;
  logic accept, ack, fail;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hpd_s1_q <= 1'b0;
      hpd_s2_q <= 1'b0;
      hpd_s3_q <= 1'b0;
    end else begin
      hpd_s1_q <= hpd_i;
      hpd_s2_q <= hpd_s1_q;
      hpd_s3_q <= hpd_s2_q;
    end
  end

  always_comb begin
    hpd_rise    = hpd_s2_q & ~hpd_s3_q;
    restart_ev  = start_i | hpd_rise;
    restart_now = restart_ev | pend_q;
    accept      = tx_valid_q & tx.tx_ready_i;
    ack         = tx.tx_done_i & ~tx.tx_nack_i;
    fail        = (tx.tx_done_i & tx.tx_nack_i) | (~tx.tx_done_i & (cnt_q == TMO_LAST));

    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pend_d     = pend_q | restart_ev;
    do_restart = 1'b0;
`ifdef ADV_INIT_RETRY_EN
    retry_d    = retry_q;
`endif

    unique case (state_q)
      S_WAIT_PWR: begin
        idx_d = '0;
        if (restart_now) begin
          do_restart = 1'b1;
        end else if (cnt_q == PWR_LAST) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Once accepted, the offer is committed; a restart then waits for the outcome.
      S_ISSUE: begin
        if (accept) begin
          state_d = S_WAIT_DONE;
          cnt_d   = '0;
        end else if (restart_now) begin
          do_restart = 1'b1;
        end
      end

      S_WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (ack || fail) begin
          cnt_d = '0;
          if (restart_now) begin
            do_restart = 1'b1;
          end else if (ack) begin
`ifdef ADV_INIT_RETRY_EN
            retry_d = '0;
`endif
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 4'd1;
              state_d = S_GAP;
            end
          end else begin
`ifdef ADV_INIT_RETRY_EN
            if (retry_q == 4'(MAX_RETRY)) begin
              state_d = S_ERROR;
            end else begin
              retry_d = retry_q + 4'd1;
              state_d = S_GAP;
            end
`else
            state_d = S_ERROR;
`endif
          end
        end
      end

      S_GAP: begin
        if (restart_now) begin
          do_restart = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DONE, S_ERROR: begin
        if (restart_now) do_restart = 1'b1;
      end

      default: do_restart = 1'b1;
    endcase

    if (do_restart) begin
      state_d = S_WAIT_PWR;
      cnt_d   = '0;
      idx_d   = '0;
      pend_d  = 1'b0;
`ifdef ADV_INIT_RETRY_EN
      retry_d = '0;
`endif
    end

    // Outputs are registered images of the next state so reset can hold them all low.
    tx_valid_d = (state_d == S_ISSUE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERROR);
    busy_d     = ~(done_d | err_d);
    tx_data_d  = tx_valid_d ? TX_W'({DEV_ADDR, tbl_entry(idx_d)}) : tx_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_WAIT_PWR;
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef ADV_INIT_RETRY_EN
      retry_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef ADV_INIT_RETRY_EN
      retry_q    <= retry_d;
`endif
    end
  end

  assign tx.tx_valid_o = tx_valid_q;
  assign tx.tx_data_o  = tx_data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign trans_idx_o   = idx_q;

endmodule

// File: tb/tb_adv7511_init_sequencer.sv
// Randomised bench for adv7511_init_sequencer: an I2C-master model with random ready/ACK latency
// drives the handshake while a table-level model predicts every write, gap length and final status.
module tb_adv7511_init_sequencer;

  localparam int NTRANS    = 10;
  localparam int POWERUP   = 200;
  localparam int GAP       = 16;
  localparam int TIMEOUT   = 4096;
  localparam int MAX_RETRY = 3;
`ifdef ADV_INIT_RETRY_EN
  localparam int ATTEMPTS  = 1 + MAX_RETRY;
`else
  localparam int ATTEMPTS  = 1;
`endif

  localparam logic [15:0] REF_TBL [0:9] = '{16'h4110, 16'h9803, 16'h9AE0, 16'h9C30, 16'h9D61,
                                            16'hA2A4, 16'hA3A4, 16'hE0D0, 16'hF900, 16'h1500};

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        hpd   = 1'b0;
  logic        busy, done, err;
  logic [3:0]  tidx;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_acc;
  logic [23:0] first_data, last_data;

  adv7511_init_sequencer_if #(.NBYTES(3)) tx_if();

  adv7511_init_sequencer #(
    .NBYTES(3), .NTRANS(NTRANS), .DEV_ADDR(8'h72), .POWERUP_CYCLES(POWERUP),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .hpd_i(hpd), .tx(tx_if),
    .busy_o(busy), .done_o(done), .err_o(err), .trans_idx_o(tidx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start(input string tag);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"},  32'(err),  32'd0);
    chk({tag, "_idx"},  32'(tidx), 32'd0);
  endtask

  // Plays the I2C master for one whole sequence, starting POWERUP cycles before the first offer.
  task automatic run_seq(input int fail_idx, input bit fail_to, input int stall_idx,
                         input int hpd_idx, input int exp_total);
    int          exp_idx  = 0;
    int          exp_gap  = POWERUP;
    int          attempts = 0;
    int          iter     = 0;
    int          n, lat;
    bit          hpd_pend = 0, hpd_used = 0, stalled = 0, finished = 0, failing, stable;
    logic [23:0] seen;
    n_acc = 0;
    while (!finished && iter < 80) begin
      iter++;
      n = 0;
      while (tx_if.tx_valid_o !== 1'b1 && n < exp_gap + 20) begin
        @(posedge clk);
        n++;
        @(negedge clk);
        if (n == 1) chk("busy_early", 32'(busy), 32'd1);
        if (n == 3 && exp_gap >= 8) begin
          tx_if.tx_done_i = 1'b1;
          tx_if.tx_nack_i = 1'($urandom_range(0, 1));
        end else begin
          tx_if.tx_done_i = 1'b0;
          tx_if.tx_nack_i = 1'b0;
        end
      end
      tx_if.tx_done_i = 1'b0;
      tx_if.tx_nack_i = 1'b0;
      seen = tx_if.tx_data_o;
      chk("gap_cycles", 32'(n), 32'(exp_gap));
      chk("tx_data", 32'(seen), 32'({8'h72, REF_TBL[exp_idx]}));
      chk("trans_idx", 32'(tidx), 32'(exp_idx));

      if (exp_idx == stall_idx && !stalled) begin
        stalled = 1;
        stable  = 1;
        repeat (50) begin
          cyc();
          stable &= (tx_if.tx_valid_o === 1'b1) && (tx_if.tx_data_o === seen);
        end
        chk("stall_hold", 32'(stable), 32'd1);
      end else begin
        repeat ($urandom_range(0, 3)) cyc();
      end

      tx_if.tx_ready_i = 1'b1;
      cyc();
      tx_if.tx_ready_i = 1'b0;
      n_acc++;
      if (n_acc == 1) first_data = seen;
      last_data = seen;
      chk("valid_drop", 32'(tx_if.tx_valid_o), 32'd0);

      failing = (exp_idx == fail_idx);
      if (exp_idx == hpd_idx && !hpd_used) begin
        hpd_used = 1;
        hpd_pend = 1;
        hpd      = 1'b1;
      end

      if (failing && fail_to) begin
        n = 0;
        while (err !== 1'b1 && tx_if.tx_valid_o !== 1'b1 && n < TIMEOUT + GAP + 20) begin
          cyc();
          n++;
        end
        attempts++;
        if (attempts >= ATTEMPTS) begin
          chk("timeout_err_cycles", 32'(n), 32'(TIMEOUT));
          finished = 1;
        end else begin
          chk("timeout_retry_cycles", 32'(n), 32'(TIMEOUT + GAP));
          exp_gap = 0;
        end
      end else begin
        lat = $urandom_range(hpd_pend ? 6 : 1, 25);
        repeat (lat) cyc();
        tx_if.tx_done_i = 1'b1;
        tx_if.tx_nack_i = failing;
        cyc();
        tx_if.tx_done_i = 1'b0;
        tx_if.tx_nack_i = 1'b0;
        if (failing) begin
          attempts++;
          if (attempts >= ATTEMPTS) finished = 1;
          else exp_gap = GAP;
        end else begin
          attempts = 0;
          if (hpd_pend) begin
            hpd_pend = 0;
            exp_idx  = 0;
            exp_gap  = POWERUP;
          end else if (exp_idx == NTRANS - 1) begin
            finished = 1;
          end else begin
            exp_idx++;
            exp_gap = GAP;
          end
        end
      end
    end
    hpd = 1'b0;

    chk("seq_finished", 32'(finished), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    if (fail_idx >= 0) begin
      chk("err_end",  32'(err),  32'd1);
      chk("done_end", 32'(done), 32'd0);
      chk("idx_end",  32'(tidx), 32'(fail_idx));
    end else begin
      chk("done_end", 32'(done), 32'd1);
      chk("err_end",  32'(err),  32'd0);
      chk("idx_end",  32'(tidx), 32'(NTRANS - 1));
    end
    chk("n_trans", 32'(n_acc), 32'(exp_total));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tx_if.tx_ready_i = 1'b0;
    tx_if.tx_done_i  = 1'b0;
    tx_if.tx_nack_i  = 1'b0;

    // reset state and a clean pass through the table
    repeat (2) cyc();
    chk("rst_valid", 32'(tx_if.tx_valid_o), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err),  32'd0);
    chk("rst_idx",   32'(tidx), 32'd0);
    rst_n = 1'b1;
    run_seq(-1, 1'b0, -1, -1, NTRANS);
    chk("first_data", 32'(first_data), 32'h00724110);
    chk("last_data",  32'(last_data),  32'h00721500);

    // restart from DONE, with the master stalling on entry 3
    pulse_start("start_in_done");
    run_seq(-1, 1'b0, 3, -1, NTRANS);

    // NACK on entry 2 every time
    pulse_start("start_nack");
    run_seq(2, 1'b0, -1, -1, 2 + ATTEMPTS);

    // entry 5 never completes
    pulse_start("start_in_err");
    run_seq(5, 1'b1, -1, -1, 5 + ATTEMPTS);

    // hot-plug edge while entry 4 is in flight
    pulse_start("start_hpd");
    run_seq(-1, 1'b0, -1, 4, 5 + NTRANS);

    // asynchronous reset while an offer is pending
    pulse_start("start_rst");
    n = 0;
    while (tx_if.tx_valid_o !== 1'b1 && n < POWERUP + 20) begin
      cyc();
      n++;
    end
    chk("pre_rst_valid", 32'(tx_if.tx_valid_o), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(tx_if.tx_valid_o), 32'd0);
    chk("async_rst_busy",  32'(busy), 32'd0);
    chk("async_rst_done",  32'(done), 32'd0);
    @(negedge clk);
    cyc();
    rst_n = 1'b1;

    // restart during power-up wait reloads the counter
    repeat (50) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    run_seq(-1, 1'b0, -1, -1, NTRANS);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
